// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch pipeline stage. Holds the fetch PC, issues
//               instruction-RAM reads and hands {PC+4, PC} to the pre-decode
//               stage over a valid/allow_in handshake. Branch redirects from
//               ID squash the wrong-path fetch. A boot/run/halt FSM sequences
//               the first fetch after reset and parks fetch on a halt request.
// Optional    : define IF_PERF_CNT_EN to add the fetch_cnt / redirect_cnt
//               performance counter outputs.
// Ports       : clk, reset (async, active-high)
//               IPD_allow_in     - pre-decode can accept this cycle
//               ID_to_IF_bus     - {br_taken_cancel, br_target[31:0]}
//               halt_req         - level, stop fetching after current inst
//               IF_to_IPD_valid  - bus content valid
//               IF_to_IPD_bus    - {IF_PC+4, IF_PC}
//               inst_ram_en      - inst-RAM read enable
//               inst_ram_addr    - inst-RAM byte address (= IF_PC)
//               if_state         - FSM state (debug)
//               fetch_cnt, redirect_cnt (IF_PERF_CNT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000,
    parameter int          BUS_WD   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IPD_allow_in,
    input  logic [32:0]       ID_to_IF_bus,
    input  logic              halt_req,
    output logic              IF_to_IPD_valid,
    output logic [BUS_WD-1:0] IF_to_IPD_bus,
    output logic              inst_ram_en,
    output logic [31:0]       inst_ram_addr,
    output logic [1:0]        if_state
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic        w_br_cancel;
    logic [31:0] w_br_target;
    logic        w_out_valid;
    logic        w_redirect;
    logic [31:0] w_pc_plus4;

    assign w_br_cancel = ID_to_IF_bus[32];
    assign w_br_target = ID_to_IF_bus[31:0];
    assign w_pc_plus4  = pc_q + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        w_out_valid = 1'b0;
        w_redirect  = 1'b0;
        case (state_q)
            S_RUN: begin
                // A redirect squashes whatever is on the bus this cycle.
                w_out_valid = valid_q & ~w_br_cancel;
                if (w_br_cancel) begin
                    w_redirect = 1'b1;
                    pc_d       = w_br_target;
                    valid_d    = 1'b1;
                end else if (w_out_valid && IPD_allow_in) begin
                    pc_d = w_pc_plus4;
                    // The transferring instruction is delivered; the halt
                    // only parks the stage after it.
                    if (halt_req) begin
                        state_d = S_HALT;
                        valid_d = 1'b0;
                    end
                end
            end
            S_HALT: begin
                if (w_br_cancel) begin
                    w_redirect = 1'b1;
                    pc_d       = w_br_target;
                    valid_d    = 1'b1;
                    state_d    = S_RUN;
                end
            end
            default: begin
                // BOOT (and the unreachable 2'b11): ignore redirects, start
                // fetching at the reset vector next cycle.
                state_d = S_RUN;
                pc_d    = RESET_PC;
                valid_d = 1'b1;
            end
        endcase
    end

    assign IF_to_IPD_valid = w_out_valid;
    assign inst_ram_en     = w_out_valid & IPD_allow_in;
    assign inst_ram_addr   = pc_q;
    assign IF_to_IPD_bus   = {w_pc_plus4, pc_q};
    assign if_state        = state_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            if (inst_ram_en) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (w_redirect) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt    = fetch_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic        clk;
    logic        reset;
    logic        IPD_allow_in;
    logic [32:0] ID_to_IF_bus;
    logic        halt_req;
    logic        IF_to_IPD_valid;
    logic [63:0] IF_to_IPD_bus;
    logic        inst_ram_en;
    logic [31:0] inst_ram_addr;
    logic [1:0]  if_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;
`endif

    if_stage #(.RESET_PC(RST_PC), .BUS_WD(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .IPD_allow_in    (IPD_allow_in),
        .ID_to_IF_bus    (ID_to_IF_bus),
        .halt_req        (halt_req),
        .IF_to_IPD_valid (IF_to_IPD_valid),
        .IF_to_IPD_bus   (IF_to_IPD_bus),
        .inst_ram_en     (inst_ram_en),
        .inst_ram_addr   (inst_ram_addr),
        .if_state        (if_state)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt       (fetch_cnt),
        .redirect_cnt    (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        allow;
        logic        cancel;
        logic [31:0] target;
        logic        halt;
        logic        exp_valid;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic a, input logic c, input logic [31:0] t, input logic h,
                       input logic v, input logic e, input logic [31:0] ad, input logic [1:0] s);
        vec_t r;
        r.allow = a; r.cancel = c; r.target = t; r.halt = h;
        r.exp_valid = v; r.exp_en = e; r.exp_addr = ad; r.exp_state = s;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic a, input logic c, input logic [31:0] t, input logic h);
        IPD_allow_in = a;
        ID_to_IF_bus = {c, t};
        halt_req     = h;
    endtask

    task automatic compare_outputs(input string tag, input vec_t e);
        logic [31:0] nxt;
        nxt = e.exp_addr + 32'd4;
        check({tag, " valid"}, {63'd0, IF_to_IPD_valid}, {63'd0, e.exp_valid});
        check({tag, " en"},    {63'd0, inst_ram_en},     {63'd0, e.exp_en});
        check({tag, " addr"},  {32'd0, inst_ram_addr},   {32'd0, e.exp_addr});
        check({tag, " bus"},   IF_to_IPD_bus,            {nxt, e.exp_addr});
        check({tag, " state"}, {62'd0, if_state},        {62'd0, e.exp_state});
    endtask

    initial begin
        vec_t e;
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'd0, 1'b0);

        // Cycle-by-cycle table starting in the BOOT cycle after reset release.
        add(1,1,32'h1C00_0300,0, 0,0,32'h1C00_0000,2'b00); // BOOT, cancel ignored
        add(1,0,32'h0,0,         1,1,32'h1C00_0000,2'b01);
        add(1,0,32'h0,0,         1,1,32'h1C00_0004,2'b01);
        add(0,0,32'h0,0,         1,0,32'h1C00_0008,2'b01); // stall x3
        add(0,0,32'h0,0,         1,0,32'h1C00_0008,2'b01);
        add(0,0,32'h0,0,         1,0,32'h1C00_0008,2'b01);
        add(1,0,32'h0,0,         1,1,32'h1C00_0008,2'b01);
        add(0,1,32'h1C00_0100,0, 0,0,32'h1C00_000C,2'b01); // cancel during stall
        add(1,0,32'h0,0,         1,1,32'h1C00_0100,2'b01);
        add(1,1,32'h1C00_0010,0, 0,0,32'h1C00_0104,2'b01); // cancel with allow
        add(1,0,32'h0,1,         1,1,32'h1C00_0010,2'b01); // halting fetch delivered
        for (int i = 0; i < 10; i++)
            add(1,0,32'h0,i[0],  0,0,32'h1C00_0014,2'b10); // parked in HALT
        add(1,1,32'h1C00_0200,0, 0,0,32'h1C00_0014,2'b10); // exit HALT
        add(1,0,32'h0,0,         1,1,32'h1C00_0200,2'b01);
        add(0,0,32'h0,1,         1,0,32'h1C00_0204,2'b01); // halt during stall
        add(1,1,32'hFFFF_FFFC,1, 0,0,32'h1C00_0204,2'b01); // redirect beats halt
        add(1,0,32'h0,0,         1,1,32'hFFFF_FFFC,2'b01);
        add(1,0,32'h0,0,         1,1,32'h0000_0000,2'b01); // PC wrapped
        add(0,0,32'h0,1,         1,0,32'h0000_0004,2'b01); // halt pending
        add(1,0,32'h0,1,         1,1,32'h0000_0004,2'b01); // takes effect here
        add(1,0,32'h0,0,         0,0,32'h0000_0008,2'b10);

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        e.exp_valid = 1'b0; e.exp_en = 1'b0; e.exp_addr = RST_PC; e.exp_state = 2'b00;
        compare_outputs("reset", e);
`ifdef IF_PERF_CNT_EN
        check("reset fetch_cnt",    {32'd0, fetch_cnt},    64'd0);
        check("reset redirect_cnt", {32'd0, redirect_cnt}, 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].allow, tbl[i].cancel, tbl[i].target, tbl[i].halt);
            sb.push_back(tbl[i]);
            #3;
            e = sb.pop_front();
            compare_outputs($sformatf("row%0d", i), e);
            @(posedge clk);
            #1;
        end

`ifdef IF_PERF_CNT_EN
        check("fetch_cnt",    {32'd0, fetch_cnt},    64'd9);
        check("redirect_cnt", {32'd0, redirect_cnt}, 64'd4);
`endif

        // Redirect out of HALT, run a couple of fetches, then reset mid-cycle.
        drive(1'b1, 1'b1, 32'h1C00_0400, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("pre-reset addr", {32'd0, inst_ram_addr}, {32'd0, 32'h1C00_0404});
        #2 reset = 1'b1;
        #1;
        e.exp_valid = 1'b0; e.exp_en = 1'b0; e.exp_addr = RST_PC; e.exp_state = 2'b00;
        compare_outputs("async_reset", e);
`ifdef IF_PERF_CNT_EN
        check("async fetch_cnt",    {32'd0, fetch_cnt},    64'd0);
        check("async redirect_cnt", {32'd0, redirect_cnt}, 64'd0);
`endif
        @(posedge clk); #1 reset = 1'b0;
        #3;
        compare_outputs("reboot", e);
        @(posedge clk); #3;
        e.exp_valid = 1'b1; e.exp_en = 1'b1; e.exp_addr = RST_PC; e.exp_state = 2'b01;
        compare_outputs("reboot_run", e);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
